// File: rtl/counter_4b_pkg.sv
// Shared constants and direction encoding for the loadable up/down counter.
package counter_4b_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_RST   = 0;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_4b_next.sv
// Next-state logic for counter_4b: load (active-low) beats count, ASC_DESC picks direction.
module counter_4b_next
  import counter_4b_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] COUNT,
  input  logic [WIDTH-1:0] D_in,
  input  logic             LOAD,
  input  logic             ASC_DESC,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_e w_dir;

  assign w_dir = dir_e'(ASC_DESC);

  // Add/subtract wrap naturally modulo 2^WIDTH; no saturation.
  always_comb begin
    o_next = COUNT;
    if (!LOAD) begin
      o_next = D_in;
    end else if (w_dir == DIR_DOWN) begin
      o_next = COUNT - ONE;
    end else begin
      o_next = COUNT + ONE;
    end
  end

endmodule

// File: rtl/counter_4b.sv
// Loadable up/down counter with synchronous reset; COUNT comes straight from a register.
// Define COUNTER_4B_TC_EN to add the combinational terminal-count output TC.
module counter_4b
  import counter_4b_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LOAD,
  input  logic             ASC_DESC,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] COUNT
`ifdef COUNTER_4B_TC_EN
  ,
  output logic             TC
`endif
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  counter_4b_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .COUNT    (r_count),
    .D_in     (D_in),
    .LOAD     (LOAD),
    .ASC_DESC (ASC_DESC),
    .o_next   (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else begin
      r_count <= w_next;
    end
  end

  assign COUNT = r_count;

`ifdef COUNTER_4B_TC_EN
  // TC flags the value from which the next count step would wrap.
  assign TC = ((dir_e'(ASC_DESC) == DIR_UP)   && (&r_count)) ||
              ((dir_e'(ASC_DESC) == DIR_DOWN) && (r_count == '0));
`endif

endmodule

// File: tb/tb_counter_4b.sv
// Scoreboard bench for counter_4b: driver pushes hand-computed COUNT values, monitor pops and compares.
// TC is also compared when COUNTER_4B_TC_EN is defined.
module tb_counter_4b;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         LOAD;
  logic         ASC_DESC;
  logic [W-1:0] D_in;
  logic [W-1:0] COUNT;
`ifdef COUNTER_4B_TC_EN
  logic         TC;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;

  counter_4b #(
    .WIDTH   (W),
    .RST_VAL (4'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .LOAD     (LOAD),
    .ASC_DESC (ASC_DESC),
    .D_in     (D_in),
    .COUNT    (COUNT)
`ifdef COUNTER_4B_TC_EN
    ,
    .TC       (TC)
`endif
  );

  // Clock and reset defaults
  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    LOAD     = 1'b1;
    ASC_DESC = 1'b0;
    D_in     = '0;
    checks   = 0;
    errors   = 0;
  end

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Driver: applies one vector at the falling edge and queues the COUNT expected after the next rising edge.
  task automatic drive(input logic r, input logic l, input logic a,
                       input logic [W-1:0] d, input logic [W-1:0] e, input string nm);
    @(negedge clk);
    rst      = r;
    LOAD     = l;
    ASC_DESC = a;
    D_in     = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic count_seq(input logic a, input logic [W-1:0] first, input int n, input string nm);
    logic [W-1:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, a, 4'h0, v, nm);
      v = a ? v - 4'h1 : v + 4'h1;
    end
  endtask

  // Monitor / scoreboard
  logic [W-1:0] m_exp;
  string        m_name;
`ifdef COUNTER_4B_TC_EN
  logic         m_exp_tc;
`endif

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      checks++;
      if (COUNT !== m_exp) begin
        errors++;
        $display("FAIL %s: COUNT=%h expected %h at %0t", m_name, COUNT, m_exp, $time);
      end
`ifdef COUNTER_4B_TC_EN
      m_exp_tc = (!ASC_DESC && (m_exp == 4'hF)) || (ASC_DESC && (m_exp == 4'h0));
      checks++;
      if (TC !== m_exp_tc) begin
        errors++;
        $display("FAIL %s_tc: TC=%b expected %b at %0t", m_name, TC, m_exp_tc, $time);
      end
`endif
    end
  end

  // Stimulus
  initial begin
    drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, "reset");

    drive(1'b0, 1'b0, 1'b0, 4'h7, 4'h7, "load7_a");
    drive(1'b0, 1'b0, 1'b0, 4'h7, 4'h7, "load7_b");
    count_seq(1'b0, 4'h8, 10, "count_up_wrap");

    drive(1'b0, 1'b0, 1'b1, 4'hA, 4'hA, "loadA_a");
    drive(1'b0, 1'b0, 1'b1, 4'hA, 4'hA, "loadA_b");
    count_seq(1'b1, 4'h9, 14, "count_down_wrap");

    drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, "reset_mid_count");
    #2;
    checks++;
    if (COUNT !== 4'hC) begin
      errors++;
      $display("FAIL sync_reset: COUNT=%h expected %h before edge", COUNT, 4'hC);
    end
    count_seq(1'b1, 4'hF, 4, "resume_down");

    drive(1'b1, 1'b0, 1'b0, 4'h5, 4'h0, "reset_beats_load");
    drive(1'b0, 1'b0, 1'b0, 4'h3, 4'h3, "load3");
    drive(1'b0, 1'b0, 1'b0, 4'hC, 4'hC, "load_beats_count");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'hD, "up_after_load");
    drive(1'b0, 1'b1, 1'b1, 4'h0, 4'hC, "dir_change_down");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'hD, "dir_change_up");

    drive(1'b0, 1'b0, 1'b1, 4'h1, 4'h1, "track_1");
    drive(1'b0, 1'b0, 1'b0, 4'h2, 4'h2, "track_2");
    drive(1'b0, 1'b0, 1'b1, 4'h9, 4'h9, "track_9");

    drive(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, "tc_up_at_F");
    drive(1'b0, 1'b0, 1'b1, 4'hF, 4'hF, "tc_down_at_F");
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, "tc_down_at_0");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h1, "tc_up_at_1");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue depth=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
